// File: rtl/uart_pkg.sv
// Shared UART receive-path constants and the byte type used by the RX buffer.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int RX_FIFO_DEPTH_DEF = 16;
  localparam int RX_FIFO_AF_DEF    = 12;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/u_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
module u_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/u_rx_fifo.sv
// FWFT receive FIFO behind u_rx with registered flags and sticky overrun.
// Optional registered almost_full output (and AF_THRESH) under RX_FIFO_ALMOST_FULL_EN.
module u_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int DEPTH     = RX_FIFO_DEPTH_DEF,
  parameter int ADDR_W    = $clog2(DEPTH)
`ifdef RX_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH = RX_FIFO_AF_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              clr_overrun
`ifdef RX_FIFO_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovr_q, ovr_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] head;

  // A write while full is still accepted when a pop frees the slot on the same edge.
  always_comb begin
    rd_acc   = rd_en && !empty_q;
    wr_acc   = wr_en && (!full_q || rd_en);
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + ADDR_W'(rd_acc);
    count_d  = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    empty_d  = (count_d == '0);
    full_d   = (count_d == FULL_LVL);
    ovr_d    = (wr_en && full_q && !rd_en) || (ovr_q && !clr_overrun);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef RX_FIFO_ALMOST_FULL_EN
  logic af_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) af_q <= 1'b0;
    else     af_q <= (count_d >= (ADDR_W+1)'(AF_THRESH));
  end

  assign almost_full = af_q;
`endif

  u_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Memory contents are never reset, so the head is masked while empty.
  assign rd_data = empty_q ? '0 : head;
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_u_rx_fifo.sv
// Bench for u_rx_fifo: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_u_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_overrun = 1'b0;
  uart_byte_t wr_data = '0;
  uart_byte_t rd_data;
  logic       empty, full, overrun;
  logic [4:0] count;
`ifdef RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  uart_byte_t mq[$];
  bit         m_ovr = 1'b0;
  bit         m_full;
  uart_byte_t m_dump;

  u_rx_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
`ifdef RX_FIFO_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted bytes plus the sticky overrun bit.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovr = 1'b0;
    end else begin
      m_full = (mq.size() == DEPTH);
      if (wr_en && m_full && !rd_en) m_ovr = 1'b1;
      else if (clr_overrun)          m_ovr = 1'b0;
      if (rd_en && mq.size() > 0) m_dump = mq.pop_front();
      if (wr_en && (!m_full || rd_en)) mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("count", int'(count), mq.size());
      check("empty", int'(empty), int'(mq.size() == 0));
      check("full", int'(full), int'(mq.size() == DEPTH));
      check("overrun", int'(overrun), int'(m_ovr));
      if (mq.size() > 0) check("rd_data", int'(rd_data), int'(mq[0]));
      else               check("rd_data_empty", int'(rd_data), 0);
`ifdef RX_FIFO_ALMOST_FULL_EN
      check("almost_full", int'(almost_full), int'(mq.size() >= AF));
`endif
    end
  end

  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c);
    wr_en       = w;
    wr_data     = d;
    rd_en       = r;
    clr_overrun = c;
    @(negedge clk);
  endtask

  initial begin
    int pw, pr;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_count", int'(count), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_rd_data", int'(rd_data), 0);

    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    check("single_data", int'(rd_data), 'hAA);
    check("single_empty", int'(empty), 0);
    check("single_count", int'(count), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("single_pop_empty", int'(empty), 1);
    check("single_pop_data", int'(rd_data), 0);

    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("underflow_count", int'(count), 0);

    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", int'(full), 1);
    check("fill_count", int'(count), 16);

    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    check("ovr_set", int'(overrun), 1);
    check("ovr_count", int'(count), 16);
    check("ovr_head", int'(rd_data), 'h00);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovr_clr", int'(overrun), 0);

    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    check("ovr_set_wins", int'(overrun), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovr_clr2", int'(overrun), 0);

    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check("full_both_count", int'(count), 16);
    check("full_both_ovr", int'(overrun), 0);
    for (int i = 0; i < 16; i++) begin
      check("order", int'(rd_data), (i < 15) ? i + 1 : 'h77);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_empty", int'(empty), 1);

    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    check("empty_both_count", int'(count), 1);
    check("empty_both_data", int'(rd_data), 'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      check("wrap_data", int'(rd_data), (8'h80 + i) & 8'hFF);
      check("wrap_count", int'(count), 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_empty", int'(empty), 1);
    end

`ifdef RX_FIFO_ALMOST_FULL_EN
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    check("af_at_11", int'(almost_full), 0);
    cyc(1'b1, 8'h0B, 1'b0, 1'b0);
    check("af_at_12", int'(almost_full), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("af_back_11", int'(almost_full), 0);
    for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check("pre_rst_count", int'(count), 5);
    wr_en   = 1'b1;
    wr_data = 8'hC5;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_empty", int'(empty), 1);
    check("async_rst_overrun", int'(overrun), 0);
    check("async_rst_data", int'(rd_data), 0);
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 8'hE1, 1'b0, 1'b0);
    check("post_rst_data", int'(rd_data), 'hE1);
    check("post_rst_count", int'(count), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    for (int n = 0; n < 4000; n++) begin
      case ((n / 400) % 3)
        0:       begin pw = 85; pr = 25; end
        1:       begin pw = 25; pr = 85; end
        default: begin pw = 90; pr = 90; end
      endcase
      cyc(($urandom_range(99) < pw), 8'($urandom), ($urandom_range(99) < pr),
          ($urandom_range(99) < 6));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
